tt_um_neurocore: RTL and testbench

- TinyTapeout user tile holding four leaky integrate-and-fire (LIF) neurons with a shared, runtime-programmable configuration.
- Each dedicated input bit is a spike line into one neuron, scaled by that neuron's programmable signed weight.
- The tile emits one-cycle output spike pulses and a monitor nibble of a selected membrane potential.
- Sits directly under the chip-level TT harness; no other on-chip consumers.

---
 rtl/tt_neurocore_pkg.sv | 34 +++
 rtl/lif_neuron.sv | 60 ++++++
 rtl/tt_um_neurocore.sv | 90 +++++++++
 tb/tb_tt_um_neurocore.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_neurocore_pkg.sv
// Shared widths, register map and reset values for the four-neuron LIF tile.
package tt_neurocore_pkg;

    localparam int N_NEURONS = 4;
    localparam int V_W       = 8;
    localparam int REFR_W    = 4;

    localparam logic [2:0] ADDR_W0   = 3'd0;
    localparam logic [2:0] ADDR_W1   = 3'd1;
    localparam logic [2:0] ADDR_W2   = 3'd2;
    localparam logic [2:0] ADDR_W3   = 3'd3;
    localparam logic [2:0] ADDR_THR  = 3'd4;
    localparam logic [2:0] ADDR_LEAK = 3'd5;
    localparam logic [2:0] ADDR_REFR = 3'd6;
    localparam logic [2:0] ADDR_CTRL = 3'd7;

    localparam logic [V_W-1:0]    THR_RST  = 8'd64;
    localparam logic [V_W-1:0]    LEAK_RST = 8'd1;
    localparam logic [REFR_W-1:0] REFR_RST = 4'd2;

    // Clamp a two-bit-headroom signed sum back into the unsigned membrane range.
    function automatic logic [V_W-1:0] clamp_v(input logic signed [V_W+1:0] s);
        logic [V_W-1:0] r;
        if (s[V_W+1]) begin
            r = {V_W{1'b0}};
        end else if (s[V_W]) begin
            r = {V_W{1'b1}};
        end else begin
            r = s[V_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane, refractory counter and spike register.
module lif_neuron
    import tt_neurocore_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_en,
    input  logic              spike_in,
    input  logic [V_W-1:0]    weight,
    input  logic [V_W-1:0]    threshold,
    input  logic [V_W-1:0]    leak,
    input  logic [REFR_W-1:0] refr_period,
    output logic [V_W-1:0]    v,
    output logic              spike
);

    logic [V_W-1:0]          v_r;
    logic [REFR_W-1:0]       rc_r;
    logic                    spike_r;
    logic signed [V_W+1:0]   w_ext_s;
    logic signed [V_W+1:0]   sum_s;
    logic [V_W-1:0]          s_clamp_s;
    logic                    fire_s;

    // Next membrane candidate: v + weighted input - leak, saturated to 0..255.
    always_comb begin
        w_ext_s   = spike_in ? $signed({{2{weight[V_W-1]}}, weight}) : $signed({(V_W+2){1'b0}});
        sum_s     = $signed({2'b00, v_r}) + w_ext_s - $signed({2'b00, leak});
        s_clamp_s = clamp_v(sum_s);
        fire_s    = (s_clamp_s >= threshold);
    end

    // Neuron state update; when not updating, state holds and the pulse drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r     <= {V_W{1'b0}};
            rc_r    <= {REFR_W{1'b0}};
            spike_r <= 1'b0;
        end else if (upd_en) begin
            if (rc_r != {REFR_W{1'b0}}) begin
                rc_r    <= rc_r - {{(REFR_W-1){1'b0}}, 1'b1};
                v_r     <= {V_W{1'b0}};
                spike_r <= 1'b0;
            end else if (fire_s) begin
                rc_r    <= refr_period;
                v_r     <= {V_W{1'b0}};
                spike_r <= 1'b1;
            end else begin
                v_r     <= s_clamp_s;
                spike_r <= 1'b0;
            end
        end else begin
            spike_r <= 1'b0;
        end
    end

    assign v     = v_r;
    assign spike = spike_r;

endmodule

// File: rtl/tt_um_neurocore.sv
// TinyTapeout tile: config register file, input decode and output mux around four LIF neurons.
module tt_um_neurocore
    import tt_neurocore_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [V_W-1:0]       weight_r [N_NEURONS];
    logic [V_W-1:0]       thr_r;
    logic [V_W-1:0]       leak_r;
    logic [REFR_W-1:0]    refr_r;
    logic                 enable_r;

    logic                 cfg_we_s;
    logic [2:0]           cfg_addr_s;
    logic                 upd_en_s;
    logic [N_NEURONS-1:0] spike_in_s;
    logic [N_NEURONS-1:0] spike_s;
    logic [V_W-1:0]       v_s [N_NEURONS];
    logic [3:0]           mon_s;
    logic                 unused_s;

    // Input decode; a write cycle masks the spike lines since ui_in carries data.
    always_comb begin
        cfg_we_s   = ena & uio_in[7];
        cfg_addr_s = uio_in[6:4];
        upd_en_s   = ena & enable_r;
        spike_in_s = uio_in[7] ? {N_NEURONS{1'b0}} : ui_in[N_NEURONS-1:0];
        case (uio_in[1:0])
            2'd0:    mon_s = v_s[0][V_W-1:V_W-4];
            2'd1:    mon_s = v_s[1][V_W-1:V_W-4];
            2'd2:    mon_s = v_s[2][V_W-1:V_W-4];
            2'd3:    mon_s = v_s[3][V_W-1:V_W-4];
            default: mon_s = 4'h0;
        endcase
    end

    // Config register file; neurons see the old values during the write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                weight_r[i] <= {V_W{1'b0}};
            end
            thr_r    <= THR_RST;
            leak_r   <= LEAK_RST;
            refr_r   <= REFR_RST;
            enable_r <= 1'b1;
        end else if (cfg_we_s) begin
            case (cfg_addr_s)
                ADDR_W0:   weight_r[0] <= ui_in;
                ADDR_W1:   weight_r[1] <= ui_in;
                ADDR_W2:   weight_r[2] <= ui_in;
                ADDR_W3:   weight_r[3] <= ui_in;
                ADDR_THR:  thr_r       <= ui_in;
                ADDR_LEAK: leak_r      <= ui_in;
                ADDR_REFR: refr_r      <= ui_in[REFR_W-1:0];
                ADDR_CTRL: enable_r    <= ui_in[0];
                default:   enable_r    <= enable_r;
            endcase
        end
    end

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        lif_neuron u_lif (
            .clk         (clk),
            .rst_n       (rst_n),
            .upd_en      (upd_en_s),
            .spike_in    (spike_in_s[n]),
            .weight      (weight_r[n]),
            .threshold   (thr_r),
            .leak        (leak_r),
            .refr_period (refr_r),
            .v           (v_s[n]),
            .spike       (spike_s[n])
        );
    end

    assign unused_s = &{1'b0, uio_in[3:2]};
    assign uo_out   = {mon_s, spike_s};
    assign uio_out  = 8'h00;
    assign uio_oe   = 8'h00;

endmodule

// File: tb/tb_tt_um_neurocore.sv
// Self-checking bench for tt_um_neurocore: vector table, directed corner sequences, random vs model.
module tb_tt_um_neurocore;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    // Behavioural model state (plain integers)
    int       m_v  [4];
    int       m_rc [4];
    int       m_w  [4];
    logic [3:0] m_spk;
    int       m_thr, m_leak, m_refr;
    bit       m_en;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        logic       en;
        logic [7:0] exp_uo;
    } vec_t;
    vec_t tbl[$];

    tt_um_neurocore dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_v[n] = 0; m_rc[n] = 0; m_w[n] = 0;
        end
        m_spk = 4'h0; m_thr = 64; m_leak = 1; m_refr = 2; m_en = 1'b1;
    endtask

    // One clock edge of the tile, following the behavioural rules directly.
    task automatic model_edge(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        int s;
        bit in_n;
        if (!en) begin
            m_spk = 4'h0;
            return;
        end
        for (int n = 0; n < 4; n++) begin
            if (!m_en) begin
                m_spk[n] = 1'b0;
            end else if (m_rc[n] > 0) begin
                m_rc[n]--; m_v[n] = 0; m_spk[n] = 1'b0;
            end else begin
                in_n = !uio[7] && ui[n];
                s = m_v[n] + (in_n ? m_w[n] : 0) - m_leak;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                if (s >= m_thr) begin
                    m_spk[n] = 1'b1; m_v[n] = 0; m_rc[n] = m_refr;
                end else begin
                    m_spk[n] = 1'b0; m_v[n] = s;
                end
            end
        end
        if (uio[7]) begin
            case (uio[6:4])
                3'd0, 3'd1, 3'd2, 3'd3: m_w[uio[5:4]] = int'($signed(ui));
                3'd4: m_thr  = int'(ui);
                3'd5: m_leak = int'(ui);
                3'd6: m_refr = int'(ui[3:0]);
                default: m_en = ui[0];
            endcase
        end
    endtask

    function automatic logic [7:0] model_uo(input logic [1:0] sel);
        logic [7:0] vv;
        vv = 8'(m_v[sel]);
        return {vv[7:4], m_spk};
    endfunction

    task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        ui_in = ui; uio_in = uio; ena = en;
        @(posedge clk);
        model_edge(ui, uio, en);
        #1;
        check("model", uo_out, model_uo(uio[1:0]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        #3;
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Integrate-and-fire: w0=20, thr=50, leak=0, refr=0, input held
        tbl.push_back('{8'd20, 8'h80, 1'b1, 8'h00});
        tbl.push_back('{8'd50, 8'hC0, 1'b1, 8'h00});
        tbl.push_back('{8'd0,  8'hD0, 1'b1, 8'h00});
        tbl.push_back('{8'd0,  8'hE0, 1'b1, 8'h00});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 8'h10});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 8'h20});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 8'h10});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 8'h20});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{8'h00, 8'h00, 1'b1, 8'h00});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ui, tbl[i].uio, tbl[i].en);
            check($sformatf("table[%0d]", i), uo_out, tbl[i].exp_uo);
        end

        // Leak: v1 decays 99 -> 63 -> 0 and stays at 0
        do_reset();
        step(8'd200, 8'hC0, 1'b1);
        step(8'd100, 8'h90, 1'b1);
        step(8'h02, 8'h01, 1'b1);
        check("leak_v99", uo_out, 8'h60);
        for (int i = 0; i < 36; i++) step(8'h00, 8'h01, 1'b1);
        check("leak_v63", uo_out, 8'h30);
        for (int i = 0; i < 68; i++) step(8'h00, 8'h01, 1'b1);
        check("leak_floor", uo_out, 8'h00);

        // Saturation: negative weight floors at 0, positive clamps to 255 and fires
        do_reset();
        step(8'h80, 8'hA0, 1'b1);
        step(8'h00, 8'hD0, 1'b1);
        step(8'h04, 8'h02, 1'b1);
        check("sat_floor", uo_out, 8'h00);
        step(8'h7F, 8'hA0, 1'b1);
        step(8'hFF, 8'hC0, 1'b1);
        step(8'h04, 8'h02, 1'b1);
        check("sat_127", uo_out, 8'h70);
        step(8'h04, 8'h02, 1'b1);
        check("sat_254", uo_out, 8'hF0);
        step(8'h04, 8'h02, 1'b1);
        check("sat_fire", uo_out, 8'h04);

        // Refractory: refr=3 gives a firing every 4 updates, then reset mid-run
        do_reset();
        step(8'd100, 8'h80, 1'b1);
        step(8'd50,  8'hC0, 1'b1);
        step(8'd0,   8'hD0, 1'b1);
        step(8'd3,   8'hE0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(8'h01, 8'h00, 1'b1);
            check($sformatf("refr[%0d]", i), uo_out, (i % 4 == 0) ? 8'h01 : 8'h00);
        end
        do_reset();

        // Defaults after reset: threshold 64, leak 1
        step(8'd33, 8'h80, 1'b1);
        step(8'h01, 8'h00, 1'b1);
        check("dflt_v32", uo_out, 8'h20);
        step(8'h01, 8'h00, 1'b1);
        check("dflt_fire64", uo_out, 8'h01);

        // Freeze via ena=0 (writes blocked too), then via ctrl.enable=0
        do_reset();
        step(8'd20,  8'h80, 1'b1);
        step(8'd0,   8'hD0, 1'b1);
        step(8'd200, 8'hC0, 1'b1);
        step(8'h01, 8'h00, 1'b1);
        step(8'h01, 8'h00, 1'b1);
        check("frz_v40", uo_out, 8'h20);
        for (int i = 0; i < 10; i++) begin
            step(8'h01, 8'h00, 1'b0);
            check("frz_ena", uo_out, 8'h20);
        end
        step(8'd10, 8'hC0, 1'b0);
        step(8'h01, 8'h00, 1'b1);
        check("frz_resume", uo_out, 8'h30);
        step(8'h00, 8'hF0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(8'h01, 8'h00, 1'b1);
            check("frz_ctrl", uo_out, 8'h30);
        end
        step(8'h01, 8'hF0, 1'b1);
        check("frz_ctrl_wr", uo_out, 8'h30);
        step(8'h01, 8'h00, 1'b1);
        check("frz_ctrl_resume", uo_out, 8'h50);

        // Random traffic against the behavioural model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r_ui, r_uio;
            logic       r_en;
            r_ui  = 8'($urandom_range(0, 255));
            r_uio = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0) r_uio[7] = 1'b0;
            if (r_uio[7] && r_uio[6:4] == 3'd5) r_ui = 8'($urandom_range(0, 8));
            if (r_uio[7] && r_uio[6:4] == 3'd7 && $urandom_range(0, 3) != 0) r_ui[0] = 1'b1;
            r_en = ($urandom_range(0, 9) != 0);
            step(r_ui, r_uio, r_en);
            if (i % 50 == 0) begin
                check("rnd_uio_out", uio_out, 8'h00);
                check("rnd_uio_oe", uio_oe, 8'h00);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
